// File: rtl/seg_scan_if.sv
// Bundle of the scan controller's data and control signals. The controller
// is the slave side; whoever supplies segment patterns and enable is the master.
interface seg_scan_if;
    logic       en;
    logic [6:0] seg0;
    logic [6:0] seg1;
    logic [6:0] seg2;
    logic [6:0] seg3;
    logic [6:0] seg4;
    logic [6:0] seg5;
    logic [6:0] seg6;
    logic [6:0] seg7;
    logic [6:0] seg_out;
    logic [7:0] dig_sel;
    logic       frame_done;

    modport master (
        output en, seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7,
        input  seg_out, dig_sel, frame_done
    );

    modport slave (
        input  en, seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7,
        output seg_out, dig_sel, frame_done
    );
endinterface

// File: rtl/seg_scan.sv
// Multiplexed 8-digit 7-segment scanner. Each digit owns a slot of DIV
// cycles; the first BLANK cycles of every slot are dark to suppress ghosting.
// Segment patterns are captured into shadow registers only at frame
// boundaries so a frame never shows a mix of old and new data. With the scan
// disabled the shadows track the inputs so re-enabling shows current data.
module seg_scan #(
    parameter int DIV   = 1000,
    parameter int BLANK = 50
) (
    input logic       clk,
    input logic       rst,
    seg_scan_if.slave bus
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    if (DIV < 2) begin : g_bad_div
        $error("seg_scan: DIV must be at least 2");
    end
    if (BLANK < 0 || BLANK >= DIV) begin : g_bad_blank
        $error("seg_scan: BLANK must lie in 0..DIV-1");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [6:0]    sh_q [8];
    logic [6:0]    sh_d [8];
    logic          frame_done_q, frame_done_d;

    logic [6:0]    seg_in [8];
    logic          slot_end;
    logic          frame_end;
    logic          in_blank;
    logic [6:0]    seg_out_c;
    logic [7:0]    dig_sel_c;

    assign seg_in[0] = bus.seg0;
    assign seg_in[1] = bus.seg1;
    assign seg_in[2] = bus.seg2;
    assign seg_in[3] = bus.seg3;
    assign seg_in[4] = bus.seg4;
    assign seg_in[5] = bus.seg5;
    assign seg_in[6] = bus.seg6;
    assign seg_in[7] = bus.seg7;

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == 3'd7);

    // With no blanking configured the compare would be constant-false, so it
    // is not built at all.
    if (BLANK == 0) begin : g_no_blank
        assign in_blank = 1'b0;
    end else begin : g_blank
        localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
        assign in_blank = (cnt_q < BLANK_C);
    end

    // Next-state: slot timer, digit index, shadow capture and frame pulse.
    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        sh_d         = sh_q;
        frame_done_d = 1'b0;
        if (!bus.en) begin
            cnt_d = '0;
            idx_d = 3'd0;
            sh_d  = seg_in;
        end else begin
            if (slot_end) begin
                cnt_d = '0;
                idx_d = idx_q + 3'd1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            if (frame_end) begin
                sh_d         = seg_in;
                frame_done_d = 1'b1;
            end
        end
    end

    // State registers; reset clears progress and blanks the shadows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                sh_q[i] <= 7'h7F;
            end
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
            sh_q         <= sh_d;
        end
    end

    // Output decode straight from registered state; rst and en gate it
    // directly so the display goes dark without waiting for a clock edge.
    always_comb begin
        seg_out_c = 7'h7F;
        dig_sel_c = 8'hFF;
        if (!rst && bus.en && !in_blank) begin
            seg_out_c = sh_q[idx_q];
            dig_sel_c = ~(8'b1 << idx_q);
        end
    end

    assign bus.seg_out    = seg_out_c;
    assign bus.dig_sel    = dig_sel_c;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: instance A (DIV=4, BLANK=1) and instance B (DIV=2,
// BLANK=0) share stimulus and are both compared every cycle with a
// time-based reference model; directed table and sequences cover the corners.
module tb_seg_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [6:0] seg [8];

    always #5 clk = ~clk;

    seg_scan_if ifa ();
    seg_scan_if ifb ();

    assign ifa.en = en;   assign ifb.en = en;
    assign ifa.seg0 = seg[0]; assign ifb.seg0 = seg[0];
    assign ifa.seg1 = seg[1]; assign ifb.seg1 = seg[1];
    assign ifa.seg2 = seg[2]; assign ifb.seg2 = seg[2];
    assign ifa.seg3 = seg[3]; assign ifb.seg3 = seg[3];
    assign ifa.seg4 = seg[4]; assign ifb.seg4 = seg[4];
    assign ifa.seg5 = seg[5]; assign ifb.seg5 = seg[5];
    assign ifa.seg6 = seg[6]; assign ifb.seg6 = seg[6];
    assign ifa.seg7 = seg[7]; assign ifb.seg7 = seg[7];

    seg_scan #(.DIV(4), .BLANK(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    seg_scan #(.DIV(2), .BLANK(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    int checks   = 0;
    int failures = 0;

    // Reference model: time since scanning started, per instance.
    int         m_t   [2];
    logic [6:0] m_sh  [2][8];
    logic       m_fd  [2];
    int         m_div [2] = '{4, 2};
    int         m_blk [2] = '{1, 0};

    int cyc_g = 0;
    bit rec_b = 0;
    int fdq [$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_t[k]  = 0;
            m_fd[k] = 1'b0;
            for (int i = 0; i < 8; i++) m_sh[k][i] = 7'h7F;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_t[k]  = 0;
                m_fd[k] = 1'b0;
                for (int i = 0; i < 8; i++) m_sh[k][i] = 7'h7F;
            end else if (!en) begin
                m_t[k]  = 0;
                m_fd[k] = 1'b0;
                for (int i = 0; i < 8; i++) m_sh[k][i] = seg[i];
            end else begin
                m_fd[k] = (m_t[k] == 8 * m_div[k] - 1);
                if (m_fd[k]) for (int i = 0; i < 8; i++) m_sh[k][i] = seg[i];
                m_t[k] = (m_t[k] + 1) % (8 * m_div[k]);
            end
        end
    endtask

    function automatic logic [6:0] exp_seg(int k);
        int pos, dg;
        if (rst || !en) return 7'h7F;
        pos = m_t[k] % m_div[k];
        dg  = (m_t[k] / m_div[k]) % 8;
        if (pos < m_blk[k]) return 7'h7F;
        return m_sh[k][dg];
    endfunction

    function automatic logic [7:0] exp_dig(int k);
        int pos, dg;
        logic [7:0] d;
        if (rst || !en) return 8'hFF;
        pos = m_t[k] % m_div[k];
        dg  = (m_t[k] / m_div[k]) % 8;
        if (pos < m_blk[k]) return 8'hFF;
        d = 8'hFF;
        d[dg] = 1'b0;
        return d;
    endfunction

    task automatic check_model();
        chk("A_seg_model", ifa.seg_out,    exp_seg(0));
        chk("A_dig_model", ifa.dig_sel,    exp_dig(0));
        chk("A_fd_model",  ifa.frame_done, m_fd[0]);
        chk("B_seg_model", ifb.seg_out,    exp_seg(1));
        chk("B_dig_model", ifb.dig_sel,    exp_dig(1));
        chk("B_fd_model",  ifb.frame_done, m_fd[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
        cyc_g++;
        if (rec_b && ifb.frame_done === 1'b1) fdq.push_back(cyc_g);
    endtask

    typedef struct {
        int         cyc;
        logic [6:0] seg3_drv;
        logic [6:0] seg_exp;
        logic [7:0] dig_exp;
        logic       fd_exp;
    } vec_t;

    vec_t tbl [19];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int bad;
        int r;

        // Frame 1 blank, frame 2 data, seg3 changed mid frame 2 (cycle 53).
        tbl[0]  = '{0,  7'h79, 7'h7F, 8'hFF, 1'b0};
        tbl[1]  = '{1,  7'h79, 7'h7F, 8'hFE, 1'b0};
        tbl[2]  = '{3,  7'h79, 7'h7F, 8'hFE, 1'b0};
        tbl[3]  = '{4,  7'h79, 7'h7F, 8'hFF, 1'b0};
        tbl[4]  = '{5,  7'h79, 7'h7F, 8'hFD, 1'b0};
        tbl[5]  = '{13, 7'h79, 7'h7F, 8'hF7, 1'b0};
        tbl[6]  = '{29, 7'h79, 7'h7F, 8'h7F, 1'b0};
        tbl[7]  = '{31, 7'h79, 7'h7F, 8'h7F, 1'b0};
        tbl[8]  = '{32, 7'h79, 7'h7F, 8'hFF, 1'b1};
        tbl[9]  = '{33, 7'h79, 7'h02, 8'hFE, 1'b0};
        tbl[10] = '{35, 7'h79, 7'h02, 8'hFE, 1'b0};
        tbl[11] = '{36, 7'h79, 7'h7F, 8'hFF, 1'b0};
        tbl[12] = '{37, 7'h79, 7'h4F, 8'hFD, 1'b0};
        tbl[13] = '{45, 7'h79, 7'h79, 8'hF7, 1'b0};
        tbl[14] = '{53, 7'h33, 7'h24, 8'hDF, 1'b0};
        tbl[15] = '{61, 7'h33, 7'h0F, 8'h7F, 1'b0};
        tbl[16] = '{63, 7'h33, 7'h0F, 8'h7F, 1'b0};
        tbl[17] = '{64, 7'h33, 7'h7F, 8'hFF, 1'b1};
        tbl[18] = '{77, 7'h33, 7'h33, 8'hF7, 1'b0};

        rst = 1'b1;
        en  = 1'b1;
        seg = '{7'h02, 7'h4F, 7'h12, 7'h79, 7'h4C, 7'h24, 7'h20, 7'h0F};
        model_reset();
        #1;
        chk("rst_A_seg", ifa.seg_out, 7'h7F);
        chk("rst_A_dig", ifa.dig_sel, 8'hFF);
        chk("rst_A_fd",  ifa.frame_done, 1'b0);
        chk("rst_B_dig", ifb.dig_sel, 8'hFF);
        tick();
        tick();

        rst   = 1'b0;
        c     = 0;
        cyc_g = 0;
        rec_b = 1;
        for (int i = 0; i < 19; i++) begin
            while (c < tbl[i].cyc) begin
                tick();
                c++;
            end
            chk($sformatf("tbl_seg_c%0d", c), ifa.seg_out,    tbl[i].seg_exp);
            chk($sformatf("tbl_dig_c%0d", c), ifa.dig_sel,    tbl[i].dig_exp);
            chk($sformatf("tbl_fd_c%0d",  c), ifa.frame_done, tbl[i].fd_exp);
            seg[3] = tbl[i].seg3_drv;
        end

        // Frame 4, slot 2, second cycle.
        while (c < 105) begin
            tick();
            c++;
        end
        rec_b = 0;
        chk("slot2_seg", ifa.seg_out, 7'h12);
        chk("slot2_dig", ifa.dig_sel, 8'hFB);

        chk("B_fd_count", (fdq.size() >= 5), 1'b1);
        if (fdq.size() > 0) chk("B_fd_first", fdq[0], 16);
        for (int i = 1; i < fdq.size(); i++) chk("B_fd_period", fdq[i] - fdq[i-1], 16);

        // Drop en mid-slot: outputs go dark at once, no frame pulse.
        en = 1'b0;
        #1;
        chk("en_drop_seg", ifa.seg_out, 7'h7F);
        chk("en_drop_dig", ifa.dig_sel, 8'hFF);
        seg[0] = 7'h40;
        repeat (3) begin
            tick();
            chk("en_low_seg", ifa.seg_out, 7'h7F);
            chk("en_low_dig", ifa.dig_sel, 8'hFF);
            chk("en_low_fd",  ifa.frame_done, 1'b0);
        end
        en = 1'b1;
        #1;
        chk("en_rise_seg", ifa.seg_out, 7'h7F);
        chk("en_rise_dig", ifa.dig_sel, 8'hFF);
        tick();
        chk("en_rise1_seg", ifa.seg_out, 7'h40);
        chk("en_rise1_dig", ifa.dig_sel, 8'hFE);

        // Asynchronous reset between edges, mid-slot.
        repeat (5) tick();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_A_seg", ifa.seg_out, 7'h7F);
        chk("arst_A_dig", ifa.dig_sel, 8'hFF);
        chk("arst_A_fd",  ifa.frame_done, 1'b0);
        chk("arst_B_seg", ifb.seg_out, 7'h7F);
        chk("arst_B_dig", ifb.dig_sel, 8'hFF);
        tick();
        tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (ifa.seg_out !== 7'h7F) bad++;
            tick();
        end
        chk("arst_first_frame_blank", bad, 0);
        chk("arst_frame_done", ifa.frame_done, 1'b1);
        tick();
        chk("arst_second_frame_seg", ifa.seg_out, 7'h40);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (rst) rst = 1'b0;
            r = $urandom_range(0, 199);
            if (r < 20) seg[$urandom_range(0, 7)] = 7'($urandom);
            if (en && r >= 20 && r < 23) en = 1'b0;
            else if (!en && r >= 20 && r < 60) en = 1'b1;
            if (r == 100) begin
                #2;
                rst = 1'b1;
                model_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
